// File: rtl/qspi_packer_pkg.sv
// Shared types and constants for the QSPI page packer.
package qspi_packer_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WREN = 2'd1,
    HDR  = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam int          BYTE_W       = 8;
  localparam int          FLASH_ADDR_W = 24;
  localparam logic [7:0]  CMD_WREN_DEF = 8'h06;
  localparam logic [7:0]  CMD_PP_DEF   = 8'h02;

  // Byte counter must hold 0..page_size inclusive.
  function automatic int count_w(input int page_size);
    return $clog2(page_size) + 1;
  endfunction

endpackage

// File: rtl/qspi_page_buf.sv
// One-page byte store: synchronous write, asynchronous (zero-latency) read.
module qspi_page_buf
  import qspi_packer_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Write the accepted image byte into its slot; payload is not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/qspi_page_packer.sv
// Buffers an AXI-Stream byte image one flash page at a time and emits
// WREN + PAGE-PROGRAM command packets for each buffered page.
module qspi_page_packer
  import qspi_packer_pkg::*;
#(
  parameter int         PAGE_SIZE = 256,
  parameter logic [7:0] CMD_WREN  = CMD_WREN_DEF,
  parameter logic [7:0] CMD_PP    = CMD_PP_DEF
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [BYTE_W-1:0]       S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  input  logic                    S_AXIS_TLAST,
  input  logic [FLASH_ADDR_W-1:0] BASE_ADDR,
  output logic [BYTE_W-1:0]       M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    M_AXIS_TLAST,
  output logic                    BUSY,
  output logic [15:0]             PAGES_DONE
);

  localparam int IDX_W   = $clog2(PAGE_SIZE);
  localparam int COUNT_W = count_w(PAGE_SIZE);

  localparam logic [COUNT_W-1:0]      PAGE_CNT  = COUNT_W'(PAGE_SIZE);
  localparam logic [COUNT_W-1:0]      CNT_ONE   = COUNT_W'(1);
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [FLASH_ADDR_W-1:0] PAGE_STEP = FLASH_ADDR_W'(PAGE_SIZE);
  localparam logic [FLASH_ADDR_W-1:0] ADDR_MASK = ~(PAGE_STEP - FLASH_ADDR_W'(1));

  state_e                    state_q, state_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic [FLASH_ADDR_W-1:0]   addr_q, addr_d;
  logic                      addr_loaded_q, addr_loaded_d;
  logic                      last_img_q, last_img_d;
  logic [1:0]                idx_q, idx_d;
  logic [IDX_W-1:0]          rd_q, rd_d;
  logic [15:0]               pages_q, pages_d;
  logic                      run_q, run_d;

  logic                      buf_we;
  logic [BYTE_W-1:0]         buf_rdata;
  logic                      data_last;

  qspi_page_buf #(
    .DEPTH (PAGE_SIZE),
    .IDX_W (IDX_W)
  ) u_page_buf (
    .clk   (ACLK),
    .we    (buf_we),
    .waddr (count_q[IDX_W-1:0]),
    .wdata (S_AXIS_TDATA),
    .raddr (rd_q),
    .rdata (buf_rdata)
  );

  // Final data byte of the page currently being emitted.
  assign data_last  = ({1'b0, rd_q} == (count_q - CNT_ONE));
  assign BUSY       = !((state_q == FILL) && (count_q == '0));
  assign PAGES_DONE = pages_q;

  // Next-state, counters and AXIS outputs.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    addr_d        = addr_q;
    addr_loaded_d = addr_loaded_q;
    last_img_d    = last_img_q;
    idx_d         = idx_q;
    rd_d          = rd_q;
    pages_d       = pages_q;
    run_d         = 1'b1;
    buf_we        = 1'b0;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;

    case (state_q)
      FILL: begin
        // run_q holds TREADY low for the first cycle out of reset.
        S_AXIS_TREADY = run_q;
        if (run_q && S_AXIS_TVALID) begin
          buf_we     = 1'b1;
          count_d    = count_q + CNT_ONE;
          last_img_d = S_AXIS_TLAST;
          if (!addr_loaded_q) begin
            addr_d        = BASE_ADDR & ADDR_MASK;
            addr_loaded_d = 1'b1;
          end
          if ((count_d == PAGE_CNT) || S_AXIS_TLAST) begin
            state_d = WREN;
          end
        end
      end

      WREN: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = CMD_WREN;
        M_AXIS_TLAST  = 1'b1;
        if (M_AXIS_TREADY) begin
          state_d = HDR;
          idx_d   = 2'd0;
        end
      end

      HDR: begin
        M_AXIS_TVALID = 1'b1;
        case (idx_q)
          2'd0:    M_AXIS_TDATA = CMD_PP;
          2'd1:    M_AXIS_TDATA = addr_q[23:16];
          2'd2:    M_AXIS_TDATA = addr_q[15:8];
          default: M_AXIS_TDATA = addr_q[7:0];
        endcase
        if (M_AXIS_TREADY) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DATA;
            rd_d    = '0;
          end
        end
      end

      DATA: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = buf_rdata;
        M_AXIS_TLAST  = data_last;
        if (M_AXIS_TREADY) begin
          rd_d = rd_q + IDX_ONE;
          if (data_last) begin
            pages_d       = pages_q + 16'd1;
            addr_d        = addr_q + PAGE_STEP;
            count_d       = '0;
            addr_loaded_d = !last_img_q;
            state_d       = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= FILL;
      count_q       <= '0;
      addr_q        <= '0;
      addr_loaded_q <= 1'b0;
      last_img_q    <= 1'b0;
      idx_q         <= 2'd0;
      rd_q          <= '0;
      pages_q       <= 16'd0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      addr_loaded_q <= addr_loaded_d;
      last_img_q    <= last_img_d;
      idx_q         <= idx_d;
      rd_q          <= rd_d;
      pages_q       <= pages_d;
      run_q         <= run_d;
    end
  end

endmodule

// File: tb/tb_qspi_page_packer.sv
// Directed bench for qspi_page_packer with PAGE_SIZE=16.
module tb_qspi_page_packer;

  localparam int PS = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [7:0]  S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;
  logic [23:0] BASE_ADDR;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic        BUSY;
  logic [15:0] PAGES_DONE;

  qspi_page_packer #(.PAGE_SIZE(PS)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .BASE_ADDR     (BASE_ADDR),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .BUSY          (BUSY),
    .PAGES_DONE    (PAGES_DONE)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  start;
    logic [23:0] base;
    logic [23:0] base_rest;
    bit          rand_rdy;
    logic [15:0] exp_pages;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    hs_cnt = 0;
  int    stab_err = 0;
  int    sready_err = 0;
  bit    rand_mode = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_byte(input int i);
    if (i < got_q.size()) return got_q[i].data;
    return 8'hxx;
  endfunction

  // Downstream ready: always 1 or a coin flip per cycle.
  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      M_AXIS_TREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records beats, checks hold-while-stalled and input gating.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(M_AXIS_TVALID && M_AXIS_TDATA == prev_data && M_AXIS_TLAST == prev_last))
        stab_err <= stab_err + 1;
      if (M_AXIS_TVALID && S_AXIS_TREADY)
        sready_err <= sready_err + 1;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got_q.push_back('{data: M_AXIS_TDATA, last: M_AXIS_TLAST});
        hs_cnt <= hs_cnt + 1;
      end
      prev_stall <= M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  <= M_AXIS_TDATA;
      prev_last  <= M_AXIS_TLAST;
    end
  end

  // Called and returns at posedge+1.
  task automatic send_image(input int len, input logic [7:0] start,
                            input logic [23:0] base, input logic [23:0] base_rest);
    bit hs;
    int t;
    for (int i = 0; i < len; i++) begin
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = start + 8'(i);
      S_AXIS_TLAST  = (i == len - 1);
      BASE_ADDR     = (i == 0) ? base : base_rest;
      hs = 1'b0;
      t  = 0;
      while (!hs) begin
        @(negedge ACLK);
        hs = S_AXIS_TREADY;
        @(posedge ACLK);
        #1;
        t++;
        if (!hs && t > 3000) begin
          check("send_timeout", 32'd0, 32'd1);
          S_AXIS_TVALID = 1'b0;
          return;
        end
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic build_exp(input int len, input logic [7:0] start, input logic [23:0] base);
    logic [23:0] a;
    int npages;
    int nb;
    exp_q.delete();
    a = base & ~24'(PS - 1);
    npages = (len + PS - 1) / PS;
    for (int p = 0; p < npages; p++) begin
      exp_q.push_back('{data: 8'h06, last: 1'b1});
      exp_q.push_back('{data: 8'h02, last: 1'b0});
      exp_q.push_back('{data: a[23:16], last: 1'b0});
      exp_q.push_back('{data: a[15:8],  last: 1'b0});
      exp_q.push_back('{data: a[7:0],   last: 1'b0});
      nb = (len - p * PS < PS) ? (len - p * PS) : PS;
      for (int j = 0; j < nb; j++)
        exp_q.push_back('{data: start + 8'(p * PS + j), last: (j == nb - 1)});
      a = a + 24'(PS);
    end
  endtask

  task automatic compare_stream(input string tag, input int gb);
    check({tag, "_len"}, 32'(got_q.size() - gb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (gb + i) < got_q.size(); i++) begin
      checks++;
      if (got_q[gb + i].data !== exp_q[i].data || got_q[gb + i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL %s beat %0d: got %02h/%0b expected %02h/%0b", tag, i,
                 got_q[gb + i].data, got_q[gb + i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic wait_pages(input logic [15:0] target, input string tag);
    int t;
    t = 0;
    while (PAGES_DONE !== target && t < 3000) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    repeat (3) @(posedge ACLK);
    #1;
    check({tag, "_pages_done"}, 32'(PAGES_DONE), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int gb;
    int sb;
    int rb;
    int h0;
    int t;

    vecs[0] = '{len: 16, start: 8'h00, base: 24'h012345, base_rest: 24'h012345, rand_rdy: 1'b0, exp_pages: 16'd1};
    vecs[1] = '{len: 40, start: 8'h00, base: 24'h000000, base_rest: 24'h000000, rand_rdy: 1'b0, exp_pages: 16'd4};
    vecs[2] = '{len: 40, start: 8'h00, base: 24'h000000, base_rest: 24'h000000, rand_rdy: 1'b1, exp_pages: 16'd7};
    vecs[3] = '{len: 20, start: 8'h80, base: 24'h0ABCDE, base_rest: 24'h555555, rand_rdy: 1'b0, exp_pages: 16'd9};
    vecs[4] = '{len: 32, start: 8'h40, base: 24'hFFFFF0, base_rest: 24'hFFFFF0, rand_rdy: 1'b1, exp_pages: 16'd11};
    vecs[5] = '{len: 1,  start: 8'hC7, base: 24'h000123, base_rest: 24'h000123, rand_rdy: 1'b0, exp_pages: 16'd12};

    ARESETN       = 1'b0;
    S_AXIS_TDATA  = 8'h00;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    BASE_ADDR     = 24'h000000;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_m_tdata",  32'(M_AXIS_TDATA),  32'd0);
    check("rst_m_tlast",  32'(M_AXIS_TLAST),  32'd0);
    check("rst_busy",     32'(BUSY),          32'd0);
    check("rst_pages",    32'(PAGES_DONE),    32'd0);

    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    check("post_rst_s_tready", 32'(S_AXIS_TREADY), 32'd1);
    check("idle_busy", 32'(BUSY), 32'd0);

    for (int v = 0; v < 6; v++) begin
      rand_mode = vecs[v].rand_rdy;
      gb = got_q.size();
      sb = stab_err;
      rb = sready_err;
      build_exp(vecs[v].len, vecs[v].start, vecs[v].base);
      send_image(vecs[v].len, vecs[v].start, vecs[v].base, vecs[v].base_rest);
      wait_pages(vecs[v].exp_pages, $sformatf("v%0d", v));
      compare_stream($sformatf("v%0d", v), gb);
      check($sformatf("v%0d_busy_idle", v), 32'(BUSY), 32'd0);
      check($sformatf("v%0d_stable", v), 32'(stab_err - sb), 32'd0);
      check($sformatf("v%0d_s_tready_emit", v), 32'(sready_err - rb), 32'd0);
      if (v == 0) begin
        check("v0_wren_last", 32'(got_q[gb].last), 32'd1);
        check("v0_hdr_op", 32'(got_byte(gb + 1)), 32'h02);
        check("v0_hdr_a2", 32'(got_byte(gb + 2)), 32'h01);
        check("v0_hdr_a1", 32'(got_byte(gb + 3)), 32'h23);
        check("v0_hdr_a0", 32'(got_byte(gb + 4)), 32'h40);
      end
      if (v == 3) begin
        check("v3_hdr_a2", 32'(got_byte(gb + 2)), 32'h0A);
        check("v3_hdr_a1", 32'(got_byte(gb + 3)), 32'hBC);
        check("v3_hdr_a0", 32'(got_byte(gb + 4)), 32'hD0);
      end
      if (v == 4) begin
        check("v4_hdr0_a2", 32'(got_byte(gb + 2)),  32'hFF);
        check("v4_hdr0_a0", 32'(got_byte(gb + 4)),  32'hF0);
        check("v4_hdr1_a2", 32'(got_byte(gb + 23)), 32'h00);
        check("v4_hdr1_a1", 32'(got_byte(gb + 24)), 32'h00);
        check("v4_hdr1_a0", 32'(got_byte(gb + 25)), 32'h00);
      end
    end

    // Reset while the header address middle byte is on the bus.
    rand_mode = 1'b0;
    h0 = hs_cnt;
    send_image(16, 8'hA0, 24'h000100, 24'h000100);
    t = 0;
    while ((hs_cnt - h0) < 3 && t < 200) begin
      @(posedge ACLK);
      #2;
      t++;
    end
    check("mid_rst_reached_hdr2", 32'(hs_cnt - h0), 32'd3);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("mid_rst_m_tdata",  32'(M_AXIS_TDATA),  32'd0);
    check("mid_rst_m_tlast",  32'(M_AXIS_TLAST),  32'd0);
    check("mid_rst_busy",     32'(BUSY),          32'd0);
    check("mid_rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("mid_rst_pages",    32'(PAGES_DONE),    32'd0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    check("after_rst_s_tready", 32'(S_AXIS_TREADY), 32'd1);
    check("after_rst_busy", 32'(BUSY), 32'd0);

    gb = got_q.size();
    build_exp(5, 8'h30, 24'h000200);
    send_image(5, 8'h30, 24'h000200, 24'h000200);
    wait_pages(16'd1, "post_rst");
    compare_stream("post_rst", gb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_page_packer.md
Name: qspi_page_packer

Overview:
- Upstream feeder for qspi_programmer.
- Accepts a raw AXI4-Stream byte image and buffers it one flash page at a time.
- Emits command packets on an AXI4-Stream master port for each page: a Write-Enable (0x06), then Page-Program (0x02) with a 24-bit address followed by the page data.
- A full page is buffered before the command starts, so the programmer never sees a mid-command stall while chip-select is low.

Parameters:
- PAGE_SIZE, 256, bytes per flash page; power of two, range 16..256.
- CMD_WREN, 8'h06, write-enable opcode.
- CMD_PP, 8'h02, page-program opcode.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA  in  8  image byte
- S_AXIS_TVALID  in  1  upstream valid
- S_AXIS_TREADY  out  1  accept
- S_AXIS_TLAST  in  1  last byte of image
- BASE_ADDR  in  24  flash start address; sampled on the first byte of each image
- M_AXIS_TDATA  out  8  command byte to qspi_programmer
- M_AXIS_TVALID  out  1  valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  end of command packet (deasserts chip-select downstream)
- BUSY  out  1  high in any state other than FILL with an empty buffer
- PAGES_DONE  out  16  pages fully emitted since reset; wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert on ACLK): state=FILL, count=0, addr_loaded=0, addr=0, PAGES_DONE=0, S_AXIS_TREADY=0 during reset and 1 on first cycle after. All M_AXIS outputs and BUSY are 0.
- Reset mid-operation discards the partial page. The downstream packet is truncated; qspi_programmer reset is the system's responsibility.
- Buffer: PAGE_SIZE x 8 register array with asynchronous read, so M_AXIS_TDATA has no read latency. Count width is log2(PAGE_SIZE)+1.
- FILL:
  - S_AXIS_TREADY = 1.
  - On each handshake: write buf[count], count++.
  - If addr_loaded=0: addr <= {BASE_ADDR[23:log2(PAGE_SIZE)], zeros} (low bits forced to 0), addr_loaded <= 1.
  - last_img <= S_AXIS_TLAST.
  - Go to WREN when the handshake makes count==PAGE_SIZE, or when TLAST is accepted.
- WREN:
  - S_AXIS_TREADY = 0.
  - Drive TDATA=CMD_WREN, TLAST=1, TVALID=1.
  - On handshake go to HDR, idx=0.
- HDR:
  - TDATA = CMD_PP, then addr[23:16], addr[15:8], addr[7:0] for idx 0..3; TLAST=0.
  - idx advances on each handshake; after idx 3 go to DATA, rd=0.
- DATA:
  - TDATA = buf[rd]; TLAST = (rd==count-1).
  - rd++ on each handshake.
  - On the TLAST handshake: PAGES_DONE++, addr += PAGE_SIZE (mod 2^24), count=0.
  - addr_loaded <= !last_img; go to FILL.
- TVALID, once asserted, holds with stable TDATA/TLAST until TREADY (AXI-Stream rule). TREADY low for any number of cycles causes no data change.
- Minimum emitted length per page is 1+4+count bytes. A 1-byte image produces a 1-data-byte page.
- TLAST exactly at byte PAGE_SIZE gives a single full page and clears addr_loaded.
- Address wrap past 0xFFFFFF rolls to 0 with no error.
- FILL with count==0 and TVALID=0 is idle: BUSY=0.

Decomposition:
- Package qspi_packer_pkg holds:
  - state enum {FILL, WREN, HDR, DATA};
  - opcode localparams;
  - function clog2-based COUNT_W.
- One sub-module, qspi_page_buf: register array with a synchronous write port and an asynchronous read port.
- The FSM, counters and AXIS control stay in the top module.

Test Plan:
- PAGE_SIZE=16, BASE_ADDR=0x012345, 16 bytes 0x00..0x0F with TLAST on the last -> packet [06]TLAST; then 02,01,23,40,00..0F with TLAST on 0x0F. PAGES_DONE=1.
- 40 bytes with TLAST, BASE_ADDR=0 -> three page-program packets at addresses 000000, 000010, 000020 with 16, 16 and 8 data bytes. S_AXIS_TREADY=0 throughout each emit. PAGES_DONE=3.
- Random M_AXIS_TREADY (~50%) on the 40-byte case -> byte sequence identical to the previous scenario; TDATA stable while TVALID=1 and TREADY=0.
- Second image after TLAST with BASE_ADDR=0x0ABCDE -> header address 0A,BC,D0. A new BASE_ADDR applied mid-image is ignored.
- ARESETN pulsed low during HDR idx 2 -> all outputs 0 immediately. After release: FILL, count=0, PAGES_DONE=0; next image emits correctly.
- Address wrap: BASE_ADDR=0xFFFFF0 with 32 bytes -> headers FFFFF0 then 000000.
